evict_write_buffer: RTL

- FIFO write buffer between the cache eviction path and main-memory BRAM port B.
- Accepts whole dirty 128-bit blocks in one cycle, so eviction never waits on memory.
- Drains each block as four 32-bit word writes, gated by i_ready_mm.
- Provides a combinational snoop so the refill path can fetch a block that is still buffered instead of stale memory.

---
 rtl/evict_write_buffer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/evict_write_buffer.sv
// ---------------------------------------------------------------------------
// evict_write_buffer
//
// FIFO write buffer between the cache eviction path and main-memory BRAM
// port B. Whole dirty 128-bit blocks are accepted in a single cycle, so an
// eviction never waits on memory. Each buffered block is drained as four
// 32-bit word writes, paced by i_ready_mm. A combinational snoop lets the
// refill path read a block that is still buffered rather than stale memory.
//
// Optional feature (macro WBUF_COALESCE_EN): a push whose address matches a
// valid, non-draining entry overwrites that entry's data in place instead of
// allocating a new one.
//
// Ports:
//   clk            system clock, rising edge
//   nrst           asynchronous active-low reset
//   i_push         enqueue request for an evicted block
//   i_block_addr   block address of the evicted block (byte addr [ADDR_BITS-1:4])
//   i_block        evicted block data, word k at bits [32k+31:32k]
//   o_full         all DEPTH entries valid
//   o_empty        no valid entries
//   o_overflow     one-cycle pulse, the cycle after a push was dropped
//   i_ready_mm     memory accepts a write this cycle
//   o_addr_to_mem  word address {entry block addr, beat}
//   o_data_to_mem  word being written
//   o_we           byte write enables to BRAM port B
//   o_drain_done   pulse on the cycle the last beat of an entry is written
//   i_snoop_addr   block address requested by the refill path
//   o_snoop_hit    a valid entry matches i_snoop_addr
//   o_snoop_data   block data of the youngest matching entry (0 on miss)
// ---------------------------------------------------------------------------
module evict_write_buffer #(
    parameter int ADDR_BITS = 12,
    parameter int DEPTH     = 2,
    parameter int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_push,
    input  logic [ADDR_BITS-5:0] i_block_addr,
    input  logic [127:0]         i_block,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_overflow,
    input  logic                 i_ready_mm,
    output logic [ADDR_BITS-3:0] o_addr_to_mem,
    output logic [31:0]          o_data_to_mem,
    output logic [3:0]           o_we,
    output logic                 o_drain_done,
    input  logic [ADDR_BITS-5:0] i_snoop_addr,
    output logic                 o_snoop_hit,
    output logic [127:0]         o_snoop_data
);

    localparam int BA = ADDR_BITS - 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

    // Entry storage
    logic [BA-1:0]       addr_q [DEPTH];
    logic [127:0]        data_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS:0]   count_q;
    logic [PTR_BITS:0]   count_d;

    // Drain FSM
    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [1:0]          beat_q;
    logic [1:0]          beat_d;

    logic                overflow_q;
    logic                overflow_d;

    logic                draining;
    logic                we_fire;
    logic                pop;
    logic                push_alloc;
    logic                push_coal;
    logic                coal_hit;
    logic [PTR_BITS-1:0] coal_idx;
    logic [PTR_BITS-1:0] snoop_idx;

    // The FSM only sits in WRITE while count > 0, and rd_ptr is the entry on the wire.
    assign draining = (state_q == ST_WRITE);
    assign we_fire  = draining && i_ready_mm;
    assign pop      = we_fire && (beat_q == 2'd3);

    assign o_we          = we_fire ? 4'hF : 4'h0;
    assign o_drain_done  = pop;
    assign o_addr_to_mem = draining ? {addr_q[rd_ptr_q], beat_q} : '0;
    assign o_data_to_mem = draining ? data_q[rd_ptr_q][{beat_q, 5'b00000} +: 32] : '0;

    assign o_full     = (count_q == CNT_FULL);
    assign o_empty    = (count_q == '0);
    assign o_overflow = overflow_q;

`ifdef WBUF_COALESCE_EN
    // Only a non-draining entry may be overwritten; the draining one is already
    // partly in memory, so a matching push must allocate behind it.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == i_block_addr) &&
                !(draining && (PTR_BITS'(i) == rd_ptr_q))) begin
                coal_hit = 1'b1;
                coal_idx = PTR_BITS'(i);
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    // A full buffer can still accept a push on the cycle its head entry pops;
    // wr_ptr == rd_ptr then, so the new entry reuses the freed slot.
    assign push_coal  = i_push && coal_hit;
    assign push_alloc = i_push && !coal_hit && (!o_full || pop);
    assign overflow_d = i_push && !coal_hit && !push_alloc;

    always_comb begin
        count_d = count_q;
        if (push_alloc && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_alloc && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                // Look at the incoming push too, so a block pushed into an empty
                // buffer is on the wire the very next cycle.
                if ((count_q != '0) || push_alloc) begin
                    state_d = ST_WRITE;
                    beat_d  = 2'd0;
                end
            end
            ST_WRITE: begin
                if (we_fire) begin
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = (count_d != '0) ? ST_WRITE : ST_IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Snoop: walk oldest to youngest so the youngest match wins.
    always_comb begin
        o_snoop_hit  = 1'b0;
        o_snoop_data = '0;
        snoop_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            snoop_idx = rd_ptr_q + PTR_BITS'(i);
            if (valid_q[snoop_idx] && (addr_q[snoop_idx] == i_snoop_addr)) begin
                o_snoop_hit  = 1'b1;
                o_snoop_data = data_q[snoop_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            beat_q     <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            // Pop clears first so a same-slot push (full + pop) leaves it valid.
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_ONE;
            end
            if (push_alloc) begin
                addr_q[wr_ptr_q]  <= i_block_addr;
                data_q[wr_ptr_q]  <= i_block;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_ONE;
            end
            if (push_coal) begin
                data_q[coal_idx] <= i_block;
            end
        end
    end

endmodule
